// File: rtl/banked_mem_ctrl.sv
// Word/half-word memory controller with req/ack handshake, programmable wait states,
// misalignment error and a post-reset init sequencer that clears the array and loads boot words.
module banked_mem_ctrl #(
    parameter int unsigned    DW       = 16,
    parameter int unsigned    AW       = 6,
    parameter int unsigned    WAIT_ST  = 1,
    parameter bit             SIGN_EXT = 1'b1,
    parameter logic [DW-1:0]  BOOT0    = DW'(16'h02F0),
    parameter logic [DW-1:0]  BOOT1    = DW'(16'h22E8),
    parameter logic [DW-1:0]  BOOT2    = DW'(16'h02E2)
) (
    input  logic          clk,
    input  logic          proc_rst,
    input  logic          req,
    input  logic          we,
    input  logic          lane,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam int unsigned HW    = DW / 2;
    localparam int unsigned IW    = AW - 1;
    localparam int unsigned DEPTH = 2 ** IW;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          l_we;
    logic          l_lane;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [DW-1:0] mem [DEPTH];

    logic          a_we;
    logic          a_lane;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [IW-1:0] a_word;
    logic [DW-1:0] a_cur;
    logic [HW-1:0] a_half;
    logic [DW-1:0] a_ext;
    logic [DW-1:0] a_lane_wr;
    logic          do_access;
    logic [DW-1:0] boot_val;

    // With zero wait states the access happens on the accepting edge, so use live inputs in IDLE.
    always_comb begin
        a_we    = l_we;
        a_lane  = l_lane;
        a_addr  = l_addr;
        a_wdata = l_wdata;
        if (state == S_IDLE) begin
            a_we    = we;
            a_lane  = lane;
            a_addr  = addr;
            a_wdata = wdata;
        end
        a_word    = a_addr[AW-1:1];
        a_cur     = mem[a_word];
        a_half    = a_addr[0] ? a_cur[DW-1:HW] : a_cur[HW-1:0];
        a_ext     = SIGN_EXT ? {{HW{a_half[HW-1]}}, a_half} : {{HW{1'b0}}, a_half};
        a_lane_wr = a_addr[0] ? {a_wdata[HW-1:0], a_cur[HW-1:0]}
                              : {a_cur[DW-1:HW], a_wdata[HW-1:0]};
        do_access = ((state == S_IDLE) && req && (WAIT_ST == 0)) ||
                    ((state == S_WAIT) && (cnt == CW'(1)));
    end

    always_comb begin
        boot_val = '0;
        case (idx)
            IW'(0):  boot_val = BOOT0;
            IW'(1):  boot_val = BOOT1;
            IW'(2):  boot_val = BOOT2;
            default: boot_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state <= S_INIT;
            idx   <= '0;
            cnt   <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            busy  <= 1'b1;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_INIT: begin
                    mem[idx] <= boot_val;
                    idx      <= idx + IW'(1);
                    if (idx == IW'(DEPTH - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        l_we    <= we;
                        l_lane  <= lane;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        busy    <= 1'b1;
                        if (WAIT_ST == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(WAIT_ST);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Misaligned word accesses neither write nor return data.
            if (do_access) begin
                ack   <= 1'b1;
                rdata <= '0;
                if (!a_lane && a_addr[0]) begin
                    err <= 1'b1;
                end else if (a_we) begin
                    mem[a_word] <= a_lane ? a_lane_wr : a_wdata;
                end else begin
                    rdata <= a_lane ? a_ext : a_cur;
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Directed bench for banked_mem_ctrl (DW=16, AW=6, WAIT_ST=1, SIGN_EXT=1).
module tb_banked_mem_ctrl;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        req;
    logic        we;
    logic        lane;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        ack_seen;

    banked_mem_ctrl #(
        .DW(16), .AW(6), .WAIT_ST(1), .SIGN_EXT(1'b1),
        .BOOT0(16'h02F0), .BOOT1(16'h22E8), .BOOT2(16'h02E2)
    ) dut (
        .clk(clk), .proc_rst(proc_rst), .req(req), .we(we), .lane(lane),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One handshake: drive at a falling edge, count falling edges until ack, then drop req.
    task automatic txn(input logic w, input logic l, input logic [5:0] a, input logic [15:0] d,
                       output logic [15:0] r, output logic e, output int lt);
        @(negedge clk);
        req = 1'b1; we = w; lane = l; addr = a; wdata = d;
        lt = 0;
        do begin
            @(negedge clk);
            lt++;
        end while (!ack && lt < 20);
        r = rdata;
        e = err;
        req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(ack), 32'd0);
    endtask

    task automatic count_busy(output int cnt, output logic saw_ack);
        cnt = 0;
        saw_ack = 1'b0;
        while (busy && cnt < 100) begin
            saw_ack = saw_ack | ack;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        proc_rst = 1'b1; req = 1'b0; we = 1'b0; lane = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h0);
        proc_rst = 1'b0;
        count_busy(n, ack_seen);
        check("init_busy_cycles", 32'(n), 32'd32);
        check("init_no_ack", 32'(ack_seen), 32'd0);

        // Boot image and cleared word 3
        txn(1'b0, 1'b0, 6'd0, 16'h0, rd, er, lat);
        check("rd_w0", 32'(rd), 32'h02F0);
        check("rd_w0_lat", 32'(lat), 32'd2);
        check("rd_w0_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 6'd2, 16'h0, rd, er, lat);
        check("rd_w1", 32'(rd), 32'h22E8);
        txn(1'b0, 1'b0, 6'd4, 16'h0, rd, er, lat);
        check("rd_w2", 32'(rd), 32'h02E2);
        txn(1'b0, 1'b0, 6'd6, 16'h0, rd, er, lat);
        check("rd_w3", 32'(rd), 32'h0000);

        // Lane writes and sign-extended lane reads
        txn(1'b1, 1'b1, 6'd7, 16'h00A5, rd, er, lat);
        check("lw7_lat", 32'(lat), 32'd2);
        check("lw7_err", 32'(er), 32'd0);
        check("lw7_rdata", 32'(rd), 32'h0000);
        txn(1'b0, 1'b0, 6'd6, 16'h0, rd, er, lat);
        check("rd_a6_after_lw7", 32'(rd), 32'hA500);
        txn(1'b0, 1'b1, 6'd7, 16'h0, rd, er, lat);
        check("lr7_sext", 32'(rd), 32'hFFA5);
        txn(1'b0, 1'b1, 6'd6, 16'h0, rd, er, lat);
        check("lr6_zero", 32'(rd), 32'h0000);
        txn(1'b1, 1'b1, 6'd6, 16'hFF7C, rd, er, lat);
        txn(1'b0, 1'b0, 6'd6, 16'h0, rd, er, lat);
        check("rd_a6_both", 32'(rd), 32'hA57C);
        txn(1'b0, 1'b1, 6'd6, 16'h0, rd, er, lat);
        check("lr6_pos", 32'(rd), 32'h007C);
        txn(1'b0, 1'b1, 6'd7, 16'h0, rd, er, lat);
        check("lr7_kept", 32'(rd), 32'hFFA5);

        // Misaligned word accesses
        txn(1'b1, 1'b0, 6'd5, 16'h1234, rd, er, lat);
        check("ww5_err", 32'(er), 32'd1);
        check("ww5_rdata", 32'(rd), 32'h0000);
        txn(1'b0, 1'b0, 6'd4, 16'h0, rd, er, lat);
        check("rd_a4_unchanged", 32'(rd), 32'h02E2);
        check("rd_a4_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 6'd3, 16'h0, rd, er, lat);
        check("rd_a3_err", 32'(er), 32'd1);
        check("rd_a3_rdata", 32'(rd), 32'h0000);

        // Word write/read-back, then address wrap-around of the top word
        txn(1'b1, 1'b0, 6'd10, 16'hBEEF, rd, er, lat);
        check("ww10_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 6'd10, 16'h0, rd, er, lat);
        check("rd_a10", 32'(rd), 32'hBEEF);
        txn(1'b1, 1'b0, 6'd62, 16'h5A5A, rd, er, lat);
        txn(1'b0, 1'b0, 6'd62, 16'h0, rd, er, lat);
        check("rd_a62", 32'(rd), 32'h5A5A);

        // req held through the response: next ack WAIT_ST+2 cycles later
        @(negedge clk);
        req = 1'b1; we = 1'b0; lane = 1'b0; addr = 6'd0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ack && lat < 20);
        check("tp_first_lat", 32'(lat), 32'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 20);
        check("tp_spacing", 32'(n), 32'd3);
        check("tp_rdata", 32'(rdata), 32'h02F0);
        req = 1'b0;
        @(negedge clk);

        // Reset during WAIT aborts the write and re-initialises the array
        @(negedge clk);
        req = 1'b1; we = 1'b1; lane = 1'b0; addr = 6'd8; wdata = 16'hC0DE;
        @(negedge clk);
        check("abort_in_wait_busy", 32'(busy), 32'd1);
        proc_rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_rdata", 32'(rdata), 32'h0);
        proc_rst = 1'b0;
        count_busy(n, ack_seen);
        check("abort_busy_cycles", 32'(n), 32'd32);
        check("abort_no_ack", 32'(ack_seen), 32'd0);
        txn(1'b0, 1'b0, 6'd8, 16'h0, rd, er, lat);
        check("rd_a8_cleared", 32'(rd), 32'h0000);
        txn(1'b0, 1'b0, 6'd10, 16'h0, rd, er, lat);
        check("rd_a10_cleared", 32'(rd), 32'h0000);
        txn(1'b0, 1'b0, 6'd4, 16'h0, rd, er, lat);
        check("rd_a4_reboot", 32'(rd), 32'h02E2);

        // req held from reset release: accepted on the first IDLE edge
        @(negedge clk);
        proc_rst = 1'b1; req = 1'b1; we = 1'b0; lane = 1'b0; addr = 6'd2;
        @(negedge clk);
        proc_rst = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ack && lat < 60);
        check("held_req_lat", 32'(lat), 32'd34);
        check("held_req_rdata", 32'(rdata), 32'h22E8);
        req = 1'b0;
        @(negedge clk);
        check("held_req_pulse", 32'(ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
